// File: rtl/tt_uart_pkg.sv
// Shared state encodings, frame constants and baud divisor helper for the tt_uart serial engine.
package tt_uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT_TICK,
        TX_SHIFT
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    function automatic int calc_rx_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/tt_uart_if.sv
// Parallel-side handshakes and serial pins of the UART core; the core takes the slave view.
interface tt_uart_if;
    import tt_uart_pkg::*;

    logic                 ld_tx_req;
    logic                 ld_tx_ack;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_enable;
    logic                 tx_out;
    logic                 tx_empty;
    logic                 uld_rx_req;
    logic                 uld_rx_ack;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_enable;
    logic                 rx_in;
    logic                 rx_empty;

    modport master (
        output ld_tx_req, tx_data, tx_enable, uld_rx_req, rx_enable, rx_in,
        input  ld_tx_ack, tx_out, tx_empty, uld_rx_ack, rx_data, rx_empty
    );

    modport slave (
        input  ld_tx_req, tx_data, tx_enable, uld_rx_req, rx_enable, rx_in,
        output ld_tx_ack, tx_out, tx_empty, uld_rx_ack, rx_data, rx_empty
    );

endinterface

// File: rtl/tt_uart_baud_gen.sv
// Free-running clock-enable generator: rx_tick every RX_DIV clocks, tx_tick on every 16th rx_tick.
module tt_uart_baud_gen #(
    parameter int RX_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic rx_tick,
    output logic tx_tick
);
    import tt_uart_pkg::*;

    localparam int              DW       = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LOAD = DW'(RX_DIV - 1);
    localparam logic [3:0]      OS_LOAD  = 4'(OVERSAMPLE - 1);

    logic [DW-1:0] div_q, div_d;
    logic [3:0]    os_q, os_d;

    assign rx_tick = (div_q == '0);
    assign tx_tick = rx_tick && (os_q == '0);

    always_comb begin
        div_d = rx_tick ? DIV_LOAD : div_q - DW'(1);
        os_d  = os_q;
        if (rx_tick) begin
            os_d = (os_q == '0) ? OS_LOAD : os_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= DIV_LOAD;
            os_q  <= OS_LOAD;
        end else begin
            div_q <= div_d;
            os_q  <= os_d;
        end
    end

endmodule

// File: rtl/tt_uart_core.sv
// 8N1 UART engine with 4-phase load/unload handshakes and 16x oversampled receiver.
// state        | meaning
// TX_IDLE      | nothing held, tx_empty=1
// TX_WAIT_TICK | byte held, waiting for tx_tick with tx_enable=1
// TX_SHIFT     | start/data/stop bits going out, one per tx_tick
// RX_IDLE      | watching synchronised line for a falling edge
// RX_START     | counting to mid start bit to reject glitches
// RX_DATA      | sampling data bits at mid-bit, LSB first
// RX_STOP      | sampling stop bit, delivering byte if valid
module tt_uart_core #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic     clk,
    input  logic     reset,
    tt_uart_if.slave bus
);
    import tt_uart_pkg::*;

    localparam int         RX_DIV       = calc_rx_div(CLK_FREQ, BAUD);
    localparam logic [3:0] OS_LOAD      = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] HALF_LOAD    = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] TX_BITS_LOAD = 4'(DATA_BITS + 1);
    localparam logic [2:0] RX_BITS_LOAD = 3'(DATA_BITS - 1);

    if (RX_DIV < 1) begin : g_bad_div
        $error("tt_uart_core: CLK_FREQ/(BAUD*16) must be at least 1");
    end

    logic rx_tick, tx_tick;

    tt_uart_baud_gen #(.RX_DIV(RX_DIV)) u_baud (
        .clk     (clk),
        .reset   (reset),
        .rx_tick (rx_tick),
        .tx_tick (tx_tick)
    );

    tx_state_e            tx_state_q, tx_state_d;
    logic [DATA_BITS:0]   tx_shift_q, tx_shift_d;
    logic [3:0]           tx_cnt_q, tx_cnt_d;
    logic                 tx_out_q, tx_out_d;
    logic                 ld_ack_q, ld_ack_d;
    logic                 tx_load;

    rx_state_e            rx_state_q, rx_state_d;
    logic                 rx_sync1_q, rx_sync1_d, rx_sync2_q, rx_sync2_d, rx_prev_q, rx_prev_d;
    logic [3:0]           rx_os_q, rx_os_d;
    logic [2:0]           rx_cnt_q, rx_cnt_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic                 rx_empty_q, rx_empty_d, uld_ack_q, uld_ack_d;
    logic                 rx_fall, rx_sample, rx_unload;

    // A new load needs the previous request to have been released first.
    assign tx_load   = bus.ld_tx_req && (tx_state_q == TX_IDLE) && !ld_ack_q;
    assign rx_fall   = rx_prev_q && !rx_sync2_q;
    assign rx_sample = rx_tick && (rx_os_q == '0);
    assign rx_unload = bus.uld_rx_req && !rx_empty_q && !uld_ack_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_cnt_q   <= '0;
            tx_out_q   <= 1'b1;
            ld_ack_q   <= 1'b0;
            rx_state_q <= RX_IDLE;
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_os_q    <= '0;
            rx_cnt_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_empty_q <= 1'b1;
            uld_ack_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_out_q   <= tx_out_d;
            ld_ack_q   <= ld_ack_d;
            rx_state_q <= rx_state_d;
            rx_sync1_q <= rx_sync1_d;
            rx_sync2_q <= rx_sync2_d;
            rx_prev_q  <= rx_prev_d;
            rx_os_q    <= rx_os_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_empty_q <= rx_empty_d;
            uld_ack_q  <= uld_ack_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        unique case (tx_state_q)
            TX_IDLE:      if (tx_load) tx_state_d = TX_WAIT_TICK;
            TX_WAIT_TICK: if (tx_tick && bus.tx_enable) tx_state_d = TX_SHIFT;
            TX_SHIFT:     if (tx_tick && tx_cnt_q == '0) tx_state_d = TX_IDLE;
            default:      tx_state_d = TX_IDLE;
        endcase

        rx_state_d = rx_state_q;
        if (!bus.rx_enable) begin
            rx_state_d = RX_IDLE;
        end else begin
            unique case (rx_state_q)
                RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
                RX_START: if (rx_sample) rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
                RX_DATA:  if (rx_sample && rx_cnt_q == '0) rx_state_d = RX_STOP;
                RX_STOP:  if (rx_sample) rx_state_d = RX_IDLE;
                default:  rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_out_d   = tx_out_q;
        ld_ack_d   = ld_ack_q ? bus.ld_tx_req : tx_load;
        case (tx_state_q)
            TX_IDLE: if (tx_load) tx_shift_d = {1'b1, bus.tx_data};
            TX_WAIT_TICK: begin
                if (tx_tick && bus.tx_enable) begin
                    tx_out_d = 1'b0;
                    tx_cnt_d = TX_BITS_LOAD;
                end
            end
            TX_SHIFT: begin
                // Count zero means the stop bit has just finished; the line already idles high.
                if (tx_tick && tx_cnt_q != '0) begin
                    tx_out_d   = tx_shift_q[0];
                    tx_shift_d = {1'b1, tx_shift_q[DATA_BITS:1]};
                    tx_cnt_d   = tx_cnt_q - 4'd1;
                end
            end
            default: ;
        endcase

        rx_sync1_d = bus.rx_in;
        rx_sync2_d = rx_sync1_q;
        rx_prev_d  = rx_sync2_q;
        rx_os_d    = (rx_tick && rx_os_q != '0) ? rx_os_q - 4'd1 : rx_os_q;
        rx_cnt_d   = rx_cnt_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_empty_d = rx_unload ? 1'b1 : rx_empty_q;
        uld_ack_d  = uld_ack_q ? bus.uld_rx_req : rx_unload;
        if (bus.rx_enable) begin
            case (rx_state_q)
                RX_IDLE: if (rx_fall) rx_os_d = HALF_LOAD;
                RX_START: begin
                    if (rx_sample) begin
                        rx_os_d  = OS_LOAD;
                        rx_cnt_d = RX_BITS_LOAD;
                    end
                end
                RX_DATA: begin
                    if (rx_sample) begin
                        rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_BITS-1:1]};
                        rx_os_d    = OS_LOAD;
                        rx_cnt_d   = rx_cnt_q - 3'd1;
                    end
                end
                RX_STOP: begin
                    // Overrun and framing errors both drop the new byte silently.
                    if (rx_sample && rx_sync2_q && rx_empty_q) begin
                        rx_data_d  = rx_shift_q;
                        rx_empty_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_out     = tx_out_q;
    assign bus.tx_empty   = (tx_state_q == TX_IDLE);
    assign bus.ld_tx_ack  = ld_ack_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_empty   = rx_empty_q;
    assign bus.uld_rx_ack = uld_ack_q;

endmodule

// File: tb/tb_tt_uart_core.sv
// Self-checking bench for tt_uart_core at RX_DIV=4 (64 clocks per bit).
module tb_tt_uart_core;

    localparam int CLK_FREQ = 6400;
    localparam int BAUD     = 100;
    localparam int BIT_CLKS = 64;

    logic clk = 1'b0;
    logic reset;

    tt_uart_if u_if ();

    tt_uart_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    byte unsigned rx_exp_q[$];
    logic        tx_exp_q[$];

    typedef struct {
        byte unsigned data;
        bit           stop;
        bit           accept;
        bit           unload;
        bit           exp_empty;
        byte unsigned exp_data;
    } rx_vec_t;

    rx_vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic rx_empty_prev = 1'b1;
    always @(negedge clk) begin
        if (rx_empty_prev && !u_if.rx_empty) begin
            if (rx_exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rx_unexpected_byte: got 0x%0h, expected no byte", u_if.rx_data);
            end else begin
                check("rx_scoreboard", int'(u_if.rx_data), int'(rx_exp_q.pop_front()));
            end
        end
        rx_empty_prev <= u_if.rx_empty;
    end

    task automatic tx_load(input byte unsigned b);
        int t = 0;
        step();
        u_if.tx_data   = b;
        u_if.ld_tx_req = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!u_if.ld_tx_ack && t < 20);
        check("tx_ack_latency", t, 2);
        check("tx_empty_on_load", int'(u_if.tx_empty), 0);
        tx_exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_exp_q.push_back(b[i]);
        tx_exp_q.push_back(1'b1);
        step();
        u_if.ld_tx_req = 1'b0;
        @(negedge clk);
        check("tx_ack_hold", int'(u_if.ld_tx_ack), 1);
        @(negedge clk);
        check("tx_ack_fall", int'(u_if.ld_tx_ack), 0);
    endtask

    task automatic tx_check_frame(input int max_wait);
        int t = 0;
        while (u_if.tx_out && t < max_wait) begin
            @(negedge clk);
            t++;
        end
        if (u_if.tx_out) begin
            n_checks++;
            n_errors++;
            $display("FAIL tx_start_timeout: tx_out stayed 1 for %0d cycles, expected a start bit", t);
            tx_exp_q.delete();
            return;
        end
        repeat (BIT_CLKS / 2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("tx_bit%0d", i), int'(u_if.tx_out), int'(tx_exp_q.pop_front()));
            if (i == 9) check("tx_empty_mid_stop", int'(u_if.tx_empty), 0);
            else repeat (BIT_CLKS) @(negedge clk);
        end
        repeat (40) @(negedge clk);
        check("tx_empty_after_stop", int'(u_if.tx_empty), 1);
    endtask

    task automatic rx_send(input byte unsigned b, input bit stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            u_if.rx_in = f[i];
            repeat (BIT_CLKS) step();
        end
        u_if.rx_in = 1'b1;
    endtask

    task automatic rx_unload(input byte unsigned exp_data);
        int t = 0;
        step();
        u_if.uld_rx_req = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!u_if.uld_rx_ack && t < 20);
        check("rx_ack_latency", t, 2);
        check("rx_empty_on_unload", int'(u_if.rx_empty), 1);
        step();
        u_if.uld_rx_req = 1'b0;
        @(negedge clk);
        check("rx_ack_hold", int'(u_if.uld_rx_ack), 1);
        @(negedge clk);
        check("rx_ack_fall", int'(u_if.uld_rx_ack), 0);
        check("rx_data_kept", int'(u_if.rx_data), int'(exp_data));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lows;
        int acks;

        vecs[0] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C};
        vecs[1] = '{8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11};
        vecs[2] = '{8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11};
        vecs[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};

        reset           = 1'b1;
        u_if.ld_tx_req  = 1'b0;
        u_if.tx_data    = 8'h00;
        u_if.tx_enable  = 1'b1;
        u_if.uld_rx_req = 1'b0;
        u_if.rx_enable  = 1'b1;
        u_if.rx_in      = 1'b1;
        repeat (4) step();
        reset = 1'b0;
        @(negedge clk);
        check("reset_tx_out", int'(u_if.tx_out), 1);
        check("reset_tx_empty", int'(u_if.tx_empty), 1);
        check("reset_rx_empty", int'(u_if.rx_empty), 1);
        check("reset_ld_ack", int'(u_if.ld_tx_ack), 0);
        check("reset_uld_ack", int'(u_if.uld_rx_ack), 0);
        check("reset_rx_data", int'(u_if.rx_data), 0);

        tx_load(8'hA5);
        tx_check_frame(2 * BIT_CLKS);

        foreach (vecs[i]) begin
            if (vecs[i].accept) rx_exp_q.push_back(vecs[i].data);
            step();
            rx_send(vecs[i].data, vecs[i].stop);
            repeat (BIT_CLKS) step();
            @(negedge clk);
            check($sformatf("rx_vec%0d_empty", i), int'(u_if.rx_empty), int'(vecs[i].exp_empty));
            check($sformatf("rx_vec%0d_data", i), int'(u_if.rx_data), int'(vecs[i].exp_data));
            if (vecs[i].unload) rx_unload(vecs[i].exp_data);
        end
        check("rx_scoreboard_drained", rx_exp_q.size(), 0);

        step();
        u_if.rx_in = 1'b0;
        repeat (16) step();
        u_if.rx_in = 1'b1;
        repeat (700) step();
        @(negedge clk);
        check("rx_glitch_empty", int'(u_if.rx_empty), 1);
        check("rx_glitch_data", int'(u_if.rx_data), 0);

        // Held frame with tx_enable low, plus a request that must not be acked while busy.
        u_if.tx_enable = 1'b0;
        tx_load(8'h55);
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (!u_if.tx_out) lows++;
        end
        check("tx_gated_low_cycles", lows, 0);
        check("tx_gated_empty", int'(u_if.tx_empty), 0);
        step();
        u_if.tx_data   = 8'h0F;
        u_if.ld_tx_req = 1'b1;
        acks = 0;
        repeat (50) begin
            @(negedge clk);
            if (u_if.ld_tx_ack) acks++;
        end
        check("tx_busy_no_ack", acks, 0);
        step();
        u_if.ld_tx_req = 1'b0;
        u_if.tx_enable = 1'b1;
        tx_check_frame(BIT_CLKS + 2);

        tx_load(8'h00);
        tx_check_frame_start: begin
            int t = 0;
            while (u_if.tx_out && t < 2 * BIT_CLKS) begin
                @(negedge clk);
                t++;
            end
            check("tx_reset_frame_started", int'(u_if.tx_out), 0);
        end
        repeat (100) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("tx_reset_abort_out", int'(u_if.tx_out), 1);
        check("tx_reset_abort_empty", int'(u_if.tx_empty), 1);
        tx_exp_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
